// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
// Holds the controller state enum and the power-up pattern configuration.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN) + 1;

    // Power-up config matches the legacy fixed 10101 detector.
    localparam logic [7:0] DEF_PATTERN = 8'b0001_0101;
    localparam int         DEF_LEN     = 5;
    localparam logic       DEF_OVERLAP = 1'b0;
    localparam int         DEF_TARGET  = 0;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Config handshake bundle for seq_det_ctrl.
// master: host offering a config; slave: detector accepting it (cfg_ready).
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len,
        output cfg_overlap, cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len,
        input  cfg_overlap, cfg_target,
        output cfg_ready
    );
endinterface

// File: rtl/seq_det_ctrl_match.sv
// History shift register plus masked pattern comparator.
// Ports: clock, reset, clear, shift, data, pattern, len in; hit out (comb).
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    localparam int LW = $clog2(MAX_LEN) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic               data,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    output logic               hit
);

    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    // Newest bit sits at the LSB, so the first pattern bit is at len-1.
    assign window = {hist_q, data};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = ((window ^ pattern) & mask) == '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
        end else if (shift) begin
            hist_q <= window[MAX_LEN-2:0];
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial pattern detector controller.
// Ports: clock, reset, cfg (config handshake), start, abort, data_valid,
// data in; detected, match_count, busy, done out.
// Optional macro SEQ_DET_CTRL_TIMEOUT_EN adds TMO_W and a timeout output.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  , parameter int TMO_W   = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    seq_det_ctrl_if.slave    cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             data_valid,
    input  logic             data,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  , output logic             timeout
`endif
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PATTERN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q, len_in;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [LW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               det_q, det_d;
    logic               clear, shift, hit, match;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tmo_flag_q, tmo_flag_d;
`endif

    seq_det_match #(.MAX_LEN(MAX_LEN)) u_match (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .shift   (shift),
        .data    (data),
        .pattern (pat_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_comb begin
        if (cfg.cfg_len < LW'(2)) begin
            len_in = LW'(2);
        end else if (cfg.cfg_len > LW'(MAX_LEN)) begin
            len_in = LW'(MAX_LEN);
        end else begin
            len_in = cfg.cfg_len;
        end
    end

    assign match   = hit && (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q});
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        shift   = 1'b0;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        tmo_d      = tmo_q;
        tmo_flag_d = tmo_flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    fill_d  = '0;
                    cnt_d   = '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    tmo_d      = '0;
                    tmo_flag_d = 1'b0;
`endif
                end
            end
            RUN: begin
                // A bit arriving with abort is still scored; with a
                // bare restart it is dropped by the clear below.
                if (data_valid && (abort || !start)) begin
                    shift  = 1'b1;
                    fill_d = (fill_q == LW'(MAX_LEN)) ? fill_q
                                                      : fill_q + 1'b1;
                    if (match) begin
                        det_d = 1'b1;
                        cnt_d = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if (!abort && tgt_q != '0 && cnt_inc == tgt_q) begin
                            state_d = DONE;
                        end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                        tmo_d = '0;
`endif
                    end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    else begin
                        tmo_d = tmo_q + 1'b1;
                        if (tmo_d == '1 && !abort) begin
                            state_d    = DONE;
                            tmo_flag_d = 1'b1;
                        end
                    end
`endif
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    fill_d  = '0;
                    cnt_d   = '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    tmo_d      = '0;
                    tmo_flag_d = 1'b0;
`endif
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    fill_d  = '0;
                    cnt_d   = '0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    tmo_d      = '0;
                    tmo_flag_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fill_q  <= '0;
            cnt_q   <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q <= RST_PAT;
            len_q <= LW'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            tgt_q <= CNT_W'(DEF_TARGET);
        end else if (cfg.cfg_valid && cfg.cfg_ready) begin
            pat_q <= cfg.cfg_pattern;
            len_q <= len_in;
            ovl_q <= cfg.cfg_overlap;
            tgt_q <= cfg.cfg_target;
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign timeout = tmo_flag_q;
`endif

    assign cfg.cfg_ready = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign detected      = det_q;
    assign match_count   = cnt_q;

endmodule
